// File: rtl/lcd_strobe_pio_pkg.sv
// lcd_strobe_pio_pkg: register map, bit positions, field widths and FSM states shared by the LCD strobe PIO.
package lcd_strobe_pio_pkg;
    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_TIMING = 2'd1;
    localparam logic [1:0] ADDR_STATUS = 2'd2;
    localparam logic [1:0] ADDR_RSVD   = 2'd3;
    localparam int CNT_W     = 8;
    localparam int LVL_W     = 4;
    localparam int TM_SETUP  = 0;
    localparam int TM_PULSE  = 8;
    localparam int TM_HOLD   = 16;
    localparam int TM_IRQ_EN = 24;
    localparam int ST_BUSY   = 0;
    localparam int ST_FULL   = 1;
    localparam int ST_OVF    = 2;
    localparam int ST_DONE   = 3;
    localparam int ST_LVL    = 4;
    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_PULSE, S_HOLD} state_t;
    // A zero field still means one cycle.
    function automatic logic [CNT_W-1:0] eff_cycles(input logic [CNT_W-1:0] n);
        return n == '0 ? CNT_W'(1) : n;
    endfunction
endpackage

// File: rtl/lcd_strobe_pio_fifo.sv
// lcd_strobe_pio_fifo: synchronous write FIFO holding {rs, data} entries for the strobe sequencer.
// Ports: clk, reset (async, active high), push/din, pop/dout (show-ahead), full, empty, level.
module lcd_strobe_pio_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    // A pop frees a slot in the same cycle, so a push into a full FIFO with a pop is accepted.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign empty   = level == '0;
    assign full    = level == (AW+1)'(DEPTH);
    assign dout    = mem[rd_ptr];
    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr] <= din;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            wr_ptr <= do_push ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr <= do_pop ? rd_ptr + 1'b1 : rd_ptr;
            level  <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/lcd_strobe_pio.sv
// lcd_strobe_pio: Avalon-MM LCD bus PIO with a write FIFO and a setup/pulse/hold strobe sequencer.
// Ports: clk, reset (async, active high); Avalon slave address/chipselect/write_n/writedata/readdata;
// LCD pins out_port, rs_out, strobe_out; irq only when LCD_STROBE_PIO_IRQ_EN is defined.
module lcd_strobe_pio
    import lcd_strobe_pio_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int SETUP_RST  = 1,
    parameter int PULSE_RST  = 2,
    parameter int HOLD_RST   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic [DATA_W-1:0] out_port,
    output logic              rs_out,
    output logic              strobe_out
`ifdef LCD_STROBE_PIO_IRQ_EN
    , output logic            irq
`endif
);
    logic wr, wr_data, wr_timing, wr_status;
    logic [CNT_W-1:0] setup_r, pulse_r, hold_r, cnt;
    state_t state;
    logic [DATA_W:0] fifo_dout;
    logic fifo_full, fifo_empty, pop, last, ovf, busy, irq_en_v, done_v, unused_wd;
    logic [$clog2(FIFO_DEPTH):0] level;
    logic [LVL_W-1:0] lvl;
    assign wr        = chipselect & ~write_n;
    assign wr_data   = wr & (address == ADDR_DATA);
    assign wr_timing = wr & (address == ADDR_TIMING);
    assign wr_status = wr & (address == ADDR_STATUS);
    assign unused_wd = ^writedata;
    assign last      = cnt <= CNT_W'(1);
    // Entries are taken from IDLE or on the final HOLD cycle so queued words run back to back.
    assign pop       = ~fifo_empty & ((state == S_IDLE) | ((state == S_HOLD) & last));
    assign busy      = (state != S_IDLE) | ~fifo_empty;
    assign lvl       = 32'(level) > 32'd15 ? 4'hF : LVL_W'(level);

    lcd_strobe_pio_fifo #(.WIDTH(DATA_W+1), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wr_data),
        .din   (writedata[DATA_W:0]),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            setup_r <= CNT_W'(SETUP_RST);
            pulse_r <= CNT_W'(PULSE_RST);
            hold_r  <= CNT_W'(HOLD_RST);
            ovf     <= 1'b0;
        end else begin
            if (wr_timing) begin
                setup_r <= writedata[TM_SETUP +: CNT_W];
                pulse_r <= writedata[TM_PULSE +: CNT_W];
                hold_r  <= writedata[TM_HOLD +: CNT_W];
            end
            ovf <= (wr_data & fifo_full & ~pop) | (ovf & ~(wr_status & writedata[ST_OVF]));
        end
    end

    // Counts are loaded only on state entry, so TIMING writes never disturb a running phase.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            out_port   <= '0;
            rs_out     <= 1'b0;
            strobe_out <= 1'b0;
        end else begin
            case (state)
                S_IDLE:
                    if (pop) begin
                        {rs_out, out_port} <= fifo_dout;
                        cnt   <= eff_cycles(setup_r);
                        state <= S_SETUP;
                    end
                S_SETUP:
                    if (last) begin
                        cnt        <= eff_cycles(pulse_r);
                        strobe_out <= 1'b1;
                        state      <= S_PULSE;
                    end else cnt <= cnt - 1'b1;
                S_PULSE:
                    if (last) begin
                        cnt        <= eff_cycles(hold_r);
                        strobe_out <= 1'b0;
                        state      <= S_HOLD;
                    end else cnt <= cnt - 1'b1;
                S_HOLD:
                    if (last & pop) begin
                        {rs_out, out_port} <= fifo_dout;
                        cnt   <= eff_cycles(setup_r);
                        state <= S_SETUP;
                    end else if (last) state <= S_IDLE;
                    else cnt <= cnt - 1'b1;
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef LCD_STROBE_PIO_IRQ_EN
    logic done_set;
    assign done_set = (state == S_HOLD) & last & fifo_empty;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_en_v <= 1'b0;
            done_v   <= 1'b0;
            irq      <= 1'b0;
        end else begin
            if (wr_timing) irq_en_v <= writedata[TM_IRQ_EN];
            done_v <= done_set | (done_v & ~(wr_status & writedata[ST_DONE]));
            irq    <= done_v & irq_en_v;
        end
    end
`else
    assign irq_en_v = 1'b0;
    assign done_v   = 1'b0;
`endif

    assign readdata = address == ADDR_DATA   ? 32'({rs_out, out_port}) :
                      address == ADDR_TIMING ? {7'd0, irq_en_v, hold_r, pulse_r, setup_r} :
                      address == ADDR_STATUS ? {24'd0, lvl, done_v, ovf, fifo_full, busy} : 32'd0;
endmodule
